// File: rtl/fetch_pkg.sv
// Shared types and width helpers for the instruction-fetch slice.
package fetch_pkg;

  localparam int FETCH_ADDR_W = 16;
  localparam int FETCH_DATA_W = 16;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/clear and occupancy count; any depth >= 1.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      empty,
  output logic                      full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC-driven imem requests, in-order response buffering, flush kill.
// Define FETCH_BYPASS_EN to present a response on dec_* in its arrival cycle when the buffer is empty.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W          = FETCH_ADDR_W,
  parameter int DATA_W          = FETCH_DATA_W,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_stall,
  input  logic              flush,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc
);

  localparam int OW = cnt_w(MAX_OUTSTANDING);
  localparam int FW = cnt_w(FIFO_DEPTH);
  localparam int SW = cnt_w(FIFO_DEPTH + MAX_OUTSTANDING);
  localparam logic [SW-1:0] FIFO_LIM = SW'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  fetch_state_t    state;
  logic [OW-1:0]   out_cnt;
  logic [OW-1:0]   kill_cnt;
  logic [OW-1:0]   kill_nxt;
  logic [FW-1:0]   fifo_cnt;
  logic [SW-1:0]   pending;
  logic            fifo_empty;
  logic            fifo_full;
  logic            aq_empty;
  logic            aq_full;
  logic [ADDR_W-1:0] rsp_addr;
  entry_t          rsp_entry;
  entry_t          fifo_dout;
  entry_t          dec_entry;
  logic            credit;
  logic            accept;
  logic            rsp_fire;
  logic            rsp_keep;
  logic            fifo_push;
  logic            fifo_pop;
  logic            bypass_take;

  // Killed responses still occupy flight slots but will never land in the buffer.
  assign pending = SW'(fifo_cnt) + SW'(out_cnt) - SW'(kill_cnt);
  assign credit  = !aq_full && !fifo_full && (pending < FIFO_LIM);

  assign imem_req_valid = credit && !flush && !rst;
  assign imem_req_addr  = fetch_addr;
  assign accept         = imem_req_valid && imem_req_ready;
  assign fetch_stall    = !accept && !flush;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_fire = imem_rsp_valid && !aq_empty && !rst;
  assign rsp_keep = rsp_fire && !flush && (state == RUN);

  assign rsp_entry.pc    = rsp_addr;
  assign rsp_entry.instr = imem_rsp_data;

  assign fifo_push = rsp_keep && !bypass_take;
  assign fifo_pop  = !fifo_empty && dec_ready && !flush;

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass      = rsp_keep && fifo_empty;
  assign bypass_take = bypass && dec_ready;
  assign dec_valid   = (!fifo_empty || bypass) && !rst;
  assign dec_entry   = fifo_empty ? rsp_entry : fifo_dout;
`else
  assign bypass_take = 1'b0;
  assign dec_valid   = !fifo_empty && !rst;
  assign dec_entry   = fifo_dout;
`endif

  assign dec_pc    = dec_valid ? dec_entry.pc    : '0;
  assign dec_instr = dec_valid ? dec_entry.instr : '0;

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_addr_q (
    .clk   (clk),
    .rst   (rst),
    .clear (1'b0),
    .push  (accept),
    .pop   (rsp_fire),
    .din   (fetch_addr),
    .dout  (rsp_addr),
    .count (out_cnt),
    .empty (aq_empty),
    .full  (aq_full)
  );

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_entry_q (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (rsp_entry),
    .dout  (fifo_dout),
    .count (fifo_cnt),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // A response landing in the flush cycle is already accounted for by not counting it.
  always_comb begin
    kill_nxt = kill_cnt;
    if (flush)
      kill_nxt = out_cnt - OW'(rsp_fire);
    else if (rsp_fire && (kill_cnt != '0))
      kill_nxt = kill_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      kill_cnt <= '0;
    end else begin
      kill_cnt <= kill_nxt;
      state    <= (kill_nxt != '0) ? DRAIN : RUN;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios then randomized traffic against a queue-based model.
module tb_instr_fetch;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int FD = 4;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall;
  logic          flush;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          dec_valid;
  logic          dec_ready;
  logic [DW-1:0] dec_instr;
  logic [AW-1:0] dec_pc;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .FIFO_DEPTH      (FD),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_addr     (fetch_addr),
    .fetch_stall    (fetch_stall),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc)
  );

  typedef struct {
    logic [AW-1:0] addr;
    bit            killed;
    int            cyc;
  } req_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
  } ent_t;

  req_t mq[$];   // requests accepted by memory, oldest first
  ent_t eq[$];   // instructions decode should see, oldest first

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit auto_rsp = 0;
  bit stray    = 0;
  int rsp_pct  = 100;
  bit last_acc = 0;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    return 16'hA001 + a;
  endfunction

  function automatic int live();
    int n = 0;
    foreach (mq[i]) if (!mq[i].killed) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic observe();
    bit   credit, acc, rsp, keep, byp, dv;
    req_t r;
    ent_t e;
    if (rst) begin
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_fetch_stall", fetch_stall, 1);
      check("rst_dec_valid", dec_valid, 0);
      check("rst_dec_pc", dec_pc, 0);
      check("rst_dec_instr", dec_instr, 0);
      mq.delete();
      eq.delete();
      last_acc = 0;
      return;
    end
    credit = (mq.size() < MO) && (eq.size() + live() < FD);
    acc    = credit && !flush && imem_req_ready;
    check("req_valid", imem_req_valid, credit && !flush);
    check("fetch_stall", fetch_stall, !acc && !flush);
    if (imem_req_valid) check("req_addr", imem_req_addr, fetch_addr);
    rsp  = imem_rsp_valid && (mq.size() > 0);
    keep = 0;
    if (rsp) keep = !flush && !mq[0].killed;
`ifdef FETCH_BYPASS_EN
    byp = keep && (eq.size() == 0);
`else
    byp = 0;
`endif
    dv = (eq.size() > 0) || byp;
    check("dec_valid", dec_valid, dv);
    if (dv) begin
      if (eq.size() > 0) e = eq[0];
      else e = '{pc: mq[0].addr, instr: imem_rsp_data};
      check("dec_pc", dec_pc, e.pc);
      check("dec_instr", dec_instr, e.instr);
    end
    if (rsp) begin
      r = mq.pop_front();
      if (keep) eq.push_back('{pc: r.addr, instr: imem_rsp_data});
    end
    if (flush) begin
      eq.delete();
      foreach (mq[i]) mq[i].killed = 1;
    end else if (dec_ready && dv) begin
      void'(eq.pop_front());
    end
    if (acc) mq.push_back('{addr: fetch_addr, killed: 0, cyc: cyc});
    last_acc = acc;
  endtask

  task automatic tick();
    if (auto_rsp) begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 16'($urandom);
      if (mq.size() > 0) begin
        if (mq[0].cyc < cyc && $urandom_range(99) < rsp_pct) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = data_of(mq[0].addr);
        end
      end else if (stray && $urandom_range(99) < 10) begin
        imem_rsp_valid = 1'b1;
      end
    end
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
    if (last_acc) fetch_addr = fetch_addr + 1'b1;
  endtask

  task automatic drain();
    imem_req_ready = 1'b0;
    dec_ready      = 1'b1;
    auto_rsp       = 1'b1;
    rsp_pct        = 100;
    repeat (8) tick();
  endtask

  initial begin
    rst            = 1'b1;
    flush          = 1'b0;
    fetch_addr     = '0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 16'h1234;
    dec_ready      = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with a stray response asserted.
    tick();
    tick();
    rst            = 1'b0;
    imem_rsp_valid = 1'b0;

    // Streaming at 1-cycle latency.
    auto_rsp = 1'b1;
    rsp_pct  = 100;
    repeat (8) tick();

    // Back-pressure from decode.
    dec_ready = 1'b0;
    repeat (8) tick();
    dec_ready = 1'b1;
    repeat (10) tick();

    // Flush with two requests in flight.
    drain();
    auto_rsp       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    fetch_addr     = 16'h0010;
    tick();
    tick();
    flush      = 1'b1;
    fetch_addr = 16'h0040;
    tick();
    flush    = 1'b0;
    auto_rsp = 1'b1;
    repeat (10) tick();

    // Flush coincident with a response and a decode handshake.
    drain();
    auto_rsp       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    dec_ready      = 1'b0;
    fetch_addr     = 16'h0020;
    tick();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data_of(16'h0020);
    tick();
    imem_rsp_valid = 1'b0;
    tick();
    flush          = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data_of(16'h0021);
    dec_ready      = 1'b1;
    fetch_addr     = 16'h0080;
    tick();
    flush          = 1'b0;
    imem_rsp_valid = 1'b0;
    auto_rsp       = 1'b1;
    repeat (8) tick();

    // Single response into an empty buffer.
    drain();
    auto_rsp       = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    fetch_addr     = 16'h0005;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 16'hBEEF;
    tick();
    imem_rsp_valid = 1'b0;
    tick();
    tick();

    // Randomized traffic, redirects, stray responses and mid-run resets.
    auto_rsp = 1'b1;
    stray    = 1'b1;
    rsp_pct  = 60;
    repeat (600) begin
      imem_req_ready = ($urandom_range(99) < 70);
      dec_ready      = ($urandom_range(99) < 60);
      rst            = ($urandom_range(199) == 0);
      flush          = !rst && ($urandom_range(99) < 4);
      if (flush) fetch_addr = 16'($urandom);
      tick();
    end
    rst   = 1'b0;
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
